// File: rtl/commit_trace_streamer.sv
// Commit-trace serializer: queues retired instructions and streams each one as a 13-byte record.
// Latency: a commit in cycle N is written at the end of N, loaded at the end of N+1, and byte0 is valid in N+2.
// Backpressure: the byte is held while valid && !ready; commits that find the FIFO full are dropped and counted.
module commit_trace_streamer #(
    parameter int XLEN  = 32,   // only 32 is supported; the record layout assumes 4-byte fields
    parameter int DEPTH = 16    // power of 2, at least 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     update_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    output logic [7:0]               byte_o,
    output logic                     byte_valid_o,
    input  logic                     byte_ready_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int AW        = $clog2(DEPTH);
    localparam int REC_BYTES = 1 + 3 * XLEN / 8;
    localparam int REC_BITS  = 8 * REC_BYTES;
    localparam int IDX_W     = $clog2(REC_BYTES);

    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    // One record exactly as it goes on the wire: header byte first, then pc, instr, data (MSB first).
    typedef struct packed {
        logic [2:0]      tag;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] data;
    } rec_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    rec_t                  mem [DEPTH];
    rec_t                  new_rec;
    rec_t                  head_rec;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    state_t                state;
    logic [REC_BITS-1:0]   shreg;
    logic [IDX_W-1:0]      idx;

    logic                  nonempty;
    logic                  hs;
    logic                  last;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Format the incoming commit; a write to x0 carries no data, so the data field is zeroed.
    always_comb begin
        new_rec       = '0;
        new_rec.tag   = 3'b101;
        new_rec.rd    = reg_addr_i;
        new_rec.pc    = pc_i;
        new_rec.instr = instr_i;
        new_rec.data  = (reg_addr_i == 5'd0) ? '0 : reg_data_i;
    end

    assign head_rec = mem[rd_ptr];
    assign nonempty = (count != '0);
    assign hs       = byte_valid_o && byte_ready_i;
    assign last     = (idx == LAST_IDX);

    // A pop happens whenever the serializer can take a record: idle, or finishing the last byte.
    assign pop  = nonempty && ((state == IDLE) || (hs && last));
    // A full FIFO still accepts when the same edge frees a slot.
    assign push = update_i && !rst_i && ((count < FULL_CNT) || pop);
    assign drop = update_i && !rst_i && !push;

    // FIFO storage; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // Drop accounting: sticky flag plus a saturating counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= 16'd0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    // Serializer FSM: load a record, shift one byte out per handshake, reload without a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            byte_valid_o <= 1'b0;
            shreg        <= '0;
            idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (nonempty) begin
                        shreg        <= head_rec;
                        idx          <= '0;
                        byte_valid_o <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (byte_ready_i) begin
                        if (last) begin
                            if (nonempty) begin
                                shreg <= head_rec;
                                idx   <= '0;
                            end else begin
                                shreg        <= '0;
                                byte_valid_o <= 1'b0;
                                state        <= IDLE;
                            end
                        end else begin
                            shreg <= {shreg[REC_BITS-9:0], 8'h00};
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    byte_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign byte_o  = shreg[REC_BITS-1 -: 8];
    assign count_o = count;
    assign empty_o = (count == '0) && (state == IDLE);

endmodule

// File: doc/commit_trace_streamer.md
# commit_trace_streamer

Downstream consumer of the core's retirement trace (`pc`, `instr`, `reg_addr`, `reg_data`, `update`). It captures every committed instruction into a FIFO and serializes each record as a fixed-length byte stream over a valid/ready interface, for a UART or debug-port log sink. Records that arrive while the FIFO is full are dropped and counted.

## Interface
- `XLEN`, default 32: datapath width. The block supports 32 only; the record length is `1 + 3*XLEN/8` bytes.
- `DEPTH`, default 16: FIFO entries. Must be a power of 2 and at least 2.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `update_i`  in  1  commit strobe, one record per high cycle.
- `pc_i`  in  XLEN  PC of the committed instruction.
- `instr_i`  in  XLEN  committed instruction word.
- `reg_addr_i`  in  5  destination register. 0 means no register write.
- `reg_data_i`  in  XLEN  write-back data.
- `byte_o`  out  8  stream byte.
- `byte_valid_o`  out  1  `byte_o` is valid.
- `byte_ready_i`  in  1  sink accepts the byte.
- `empty_o`  out  1  FIFO empty and no record in flight.
- `count_o`  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the record in the shift register.
- `overflow_o`  out  1  sticky flag: at least one record was dropped.
- `drop_cnt_o`  out  16  dropped-record count. Saturates at 0xFFFF.

## Operation
- **Record format** (13 bytes, MSB-first per field):
  - byte0 = {3'b101, rd[4:0]}
  - bytes 1–4 = pc
  - bytes 5–8 = instr
  - bytes 9–12 = data
- **rd = 0:** data bytes are forced to 0x00, whatever `reg_data_i` holds.
- **Push:** when `update_i`=1, the record is written if `count_o` < DEPTH, or if a pop happens in the same cycle.
- **Drop:** otherwise the record is discarded, `overflow_o` is set, and `drop_cnt_o` increments (saturating).
- **FSM states:** IDLE and SEND.
  - IDLE: if the FIFO is not empty, pop the head into a 13-byte shift register, set the byte index to 0, and go to SEND.
  - SEND: `byte_valid_o`=1 and `byte_o` = the byte at the current index.
  - On a handshake (valid && ready) the index increments.
  - On the handshake of byte 12: if the FIFO is not empty, pop and load the next record in the same cycle (no bubble) and stay in SEND; otherwise go to IDLE.
- **Backpressure:** while `byte_valid_o`=1 and `byte_ready_i`=0, `byte_o` is held stable. `byte_valid_o` is never withdrawn before its handshake.
- **`empty_o`:** equals (count==0 && state==IDLE).
- **Full with simultaneous push and pop:** both occur; `count_o` is unchanged.

## Timing
- **Reset values:** `byte_o`=0x00, `byte_valid_o`=0, `empty_o`=1, `count_o`=0, `overflow_o`=0, `drop_cnt_o`=0. The FSM is in IDLE and the FIFO pointers are 0.
- **Update during reset:** `update_i` is ignored in any cycle where `rst_i`=1.
- **Reset mid-record:** the partial record and all FIFO contents are discarded. `byte_valid_o` is 0 from the cycle after the reset edge, and the next record starts at byte0.
- **Latency:** with `update_i` high in cycle N, the entry is written at the end of N. The FSM loads it at the end of N+1, and byte0 is valid in cycle N+2.
- **Throughput:** with `byte_ready_i` tied to 1, the output is one byte per cycle. Consecutive records are back-to-back (26 bytes in 26 cycles).
- **Sustained input:** the sink cannot keep up with one commit per cycle (13 cycles per record), so overflow is expected under sustained commits.
- **`count_o`:** updates at the edge of the push or pop; it is a registered value.

## Test plan
- **Single record:**
  - Stimulus: pc=0x80000000, instr=0x00500093, rd=1, data=5, ready=1.
  - Response: bytes A1 80 00 00 00 00 50 00 93 00 00 00 05. byte0 appears 2 cycles after `update_i`, the 13 bytes are contiguous, and `empty_o` returns to 1 afterwards.
- **rd = 0:**
  - Stimulus: pc=0x80000004, instr=0x00112023, rd=0, data=0xDEADBEEF.
  - Response: header 0xA0, data bytes 00 00 00 00.
- **Backpressure:**
  - Stimulus: ready pseudo-random at 30% high over 3 records.
  - Response: all 39 bytes in order, none duplicated or lost, and `byte_o` stable during every stall cycle.
- **Overflow:**
  - Stimulus: DEPTH=16, ready=0, `update_i` high for 20 consecutive cycles.
  - Response: 1 record in the shift register, `count_o`=16, `drop_cnt_o`=3, `overflow_o`=1. After releasing ready, exactly 17 records are emitted.
- **Full with simultaneous push and pop:**
  - Stimulus: FIFO full, last byte handshaken in the same cycle as `update_i`.
  - Response: the record is accepted, `count_o` stays 16, and `drop_cnt_o` is unchanged.
- **Reset mid-record:**
  - Stimulus: assert `rst_i` after byte 5 of a record, with 4 records queued.
  - Response: next cycle `byte_valid_o`=0, `empty_o`=1, `count_o`=0. A subsequent commit is emitted from byte0 with the correct header.
